// File: rtl/round_controller.sv
// Rock-paper-scissors round sequencer: debounces the play key, picks the active
// computer player, latches both choices, scores the round and strobes AI/display.
module round_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCORE_W         = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               play_n,
  input  logic [1:0]         mode,
  input  logic [1:0]         user,
  input  logic [1:0]         com_ra,
  input  logic [1:0]         com_m,
  input  logic [1:0]         com_re,
  input  logic               re_ready,
  input  logic               draw_done,
  output logic               learn_pulse,
  output logic               draw_start,
  output logic [1:0]         com_choice,
  output logic [1:0]         user_choice,
  output logic [SCORE_W-1:0] user_score,
  output logic [SCORE_W-1:0] com_score,
  output logic               uwin,
  output logic               cwin,
  output logic               equ,
  output logic               busy
);

  localparam int                 CNT_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [1:0]         V_DRAW    = 2'b00;
  localparam logic [1:0]         V_COM     = 2'b01;
  localparam logic [1:0]         V_USER    = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESS   = 3'd1,
    ST_SELECT  = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_DRAW    = 3'd4,
    ST_RELEASE = 3'd5
  } state_t;

  state_t           state_r, next_state_s;
  logic             sync1_r, play_s;
  logic [CNT_W-1:0] cnt_r;
  logic             cnt_clr_s, cnt_inc_s, latch_s, score_s;
  logic [1:0]       sel_s, verdict_s;

  // Choice encoding: 00 rock, 01 scissor, 10 paper; a com value of 11 scores as a draw.
  function automatic logic [1:0] judge(input logic [1:0] u, input logic [1:0] c);
    logic [1:0] v;
    case ({u, c})
      4'b0001, 4'b0110, 4'b1000: v = V_USER;
      4'b0100, 4'b1001, 4'b0010: v = V_COM;
      default:                   v = V_DRAW;
    endcase
    return v;
  endfunction

  // Two-flop synchronizer for the raw key; idles released (high).
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_r <= 1'b1;
      play_s  <= 1'b1;
    end else begin
      sync1_r <= play_n;
      play_s  <= sync1_r;
    end
  end

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:    if (!play_s) next_state_s = ST_PRESS; else next_state_s = ST_IDLE;
      ST_PRESS: begin
        if (play_s)                 next_state_s = ST_IDLE;
        else if (cnt_r == CNT_LAST) next_state_s = ST_SELECT;
        else                        next_state_s = ST_PRESS;
      end
      ST_SELECT: begin
        if (user == 2'b11)                       next_state_s = ST_RELEASE;
        else if (mode == 2'b10 && !re_ready)     next_state_s = ST_SELECT;
        else                                     next_state_s = ST_RESOLVE;
      end
      ST_RESOLVE: next_state_s = ST_DRAW;
      ST_DRAW:    if (draw_done) next_state_s = ST_RELEASE; else next_state_s = ST_DRAW;
      ST_RELEASE: begin
        if (play_s && cnt_r == CNT_LAST) next_state_s = ST_IDLE;
        else                             next_state_s = ST_RELEASE;
      end
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // Per-state control strobes for the counter and datapath.
  always_comb begin
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    latch_s   = 1'b0;
    score_s   = 1'b0;
    case (state_r)
      ST_IDLE:    cnt_clr_s = !play_s;
      ST_PRESS:   cnt_inc_s = !play_s;
      ST_SELECT:  latch_s   = (next_state_s == ST_RESOLVE);
      ST_RESOLVE: score_s   = 1'b1;
      ST_DRAW:    cnt_clr_s = draw_done;
      ST_RELEASE: begin
        if (!play_s) cnt_clr_s = 1'b1;
        else         cnt_inc_s = 1'b1;
      end
      default: begin
        cnt_clr_s = 1'b1;
      end
    endcase
  end

  // Selected computer player; 11 falls back to the random player.
  always_comb begin
    case (mode)
      2'b01:   sel_s = com_m;
      2'b10:   sel_s = com_re;
      default: sel_s = com_ra;
    endcase
    verdict_s = judge(user_choice, com_choice);
  end

  // Shared debounce counter, saturating at its terminal value.
  always_ff @(posedge CLOCK_50) begin
    if (reset)                               cnt_r <= {CNT_W{1'b0}};
    else if (cnt_clr_s)                      cnt_r <= {CNT_W{1'b0}};
    else if (cnt_inc_s && cnt_r != CNT_LAST) cnt_r <= cnt_r + CNT_W'(1);
    else                                     cnt_r <= cnt_r;
  end

  // Choice latches, scoring, strobes and busy flag.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      learn_pulse <= 1'b0;
      draw_start  <= 1'b0;
      com_choice  <= 2'b00;
      user_choice <= 2'b00;
      user_score  <= {SCORE_W{1'b0}};
      com_score   <= {SCORE_W{1'b0}};
      uwin        <= 1'b0;
      cwin        <= 1'b0;
      equ         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      learn_pulse <= score_s;
      draw_start  <= score_s;
      busy        <= (next_state_s != ST_IDLE);
      if (latch_s) begin
        com_choice  <= sel_s;
        user_choice <= user;
      end
      if (score_s) begin
        uwin <= (verdict_s == V_USER);
        cwin <= (verdict_s == V_COM);
        equ  <= (verdict_s == V_DRAW);
        if (verdict_s == V_USER && user_score != SCORE_MAX) user_score <= user_score + SCORE_W'(1);
        if (verdict_s == V_COM && com_score != SCORE_MAX)   com_score  <= com_score + SCORE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller with a round-level reference model.
module tb_round_controller;
  localparam int N  = 4;
  localparam int SW = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset, play_n, re_ready, draw_done;
  logic [1:0]    mode, user, com_ra, com_m, com_re;
  logic          learn_pulse, draw_start, uwin, cwin, equ, busy;
  logic [1:0]    com_choice, user_choice;
  logic [SW-1:0] user_score, com_score;

  always #5 clk = ~clk;

  round_controller #(.DEBOUNCE_CYCLES(N), .SCORE_W(SW)) dut (
    .CLOCK_50(clk), .reset(reset), .play_n(play_n), .mode(mode), .user(user),
    .com_ra(com_ra), .com_m(com_m), .com_re(com_re), .re_ready(re_ready),
    .draw_done(draw_done), .learn_pulse(learn_pulse), .draw_start(draw_start),
    .com_choice(com_choice), .user_choice(user_choice), .user_score(user_score),
    .com_score(com_score), .uwin(uwin), .cwin(cwin), .equ(equ), .busy(busy)
  );

  int total = 0, bad = 0;
  int lp_cnt = 0, ds_cnt = 0;
  int m_us, m_cs;
  logic m_uwin, m_cwin, m_equ;
  logic [1:0] m_cc, m_uc;

  always @(posedge clk) begin
    if (learn_pulse === 1'b1) lp_cnt <= lp_cnt + 1;
    if (draw_start === 1'b1)  ds_cnt <= ds_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic model_reset;
    m_us = 0; m_cs = 0; m_uwin = 1'b0; m_cwin = 1'b0; m_equ = 1'b0; m_cc = 2'd0; m_uc = 2'd0;
  endtask

  // Cyclic distance: (com - user) mod 3 == 1 means user wins, == 2 com wins.
  task automatic model_round(input logic [1:0] u, input logic [1:0] c);
    int d;
    m_uc = u; m_cc = c;
    d = (c == 2'd3) ? 0 : (int'(c) + 3 - int'(u)) % 3;
    m_uwin = (d == 1); m_cwin = (d == 2); m_equ = (d == 0);
    if (m_uwin && m_us < SMAX) m_us++;
    if (m_cwin && m_cs < SMAX) m_cs++;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_uscore"}, user_score, m_us);
    chk({tag, "_cscore"}, com_score, m_cs);
    chk({tag, "_flags"}, {uwin, cwin, equ}, {m_uwin, m_cwin, m_equ});
    chk({tag, "_choices"}, {com_choice, user_choice}, {m_cc, m_uc});
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 40) begin tick; k++; end
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_rel_lat"}, k, N + 2);
  endtask

  task automatic press_to_draw(input int s, output int lat, output logic [1:0] cc_seen);
    int cyc = 0;
    lat = -1; cc_seen = 2'd0;
    play_n = 1'b0; re_ready = (s == 0);
    while (cyc < 60 && lat < 0) begin
      tick; cyc++;
      if (s > 0 && cyc == 7 + s) re_ready = 1'b1;
      if (cyc == 8 + s) begin
        cc_seen = com_choice;
        com_ra = 2'($urandom); com_m = 2'($urandom); com_re = 2'($urandom); user = 2'($urandom);
      end
      if (draw_start === 1'b1) lat = cyc;
    end
  endtask

  task automatic round(input logic [1:0] u, m, cra, cm, cre, input int s, dd, hold,
                       input bit glitch, input string tag);
    int lat, cyc, lp0, ds0;
    logic [1:0] cc, csel;
    user = u; mode = m; com_ra = cra; com_m = cm; com_re = cre;
    lp0 = lp_cnt; ds0 = ds_cnt;
    csel = (m == 2'd1) ? cm : (m == 2'd2) ? cre : cra;
    model_round(u, csel);
    press_to_draw(s, lat, cc);
    chk({tag, "_lat"}, lat, 9 + s);
    chk({tag, "_cc_latch"}, cc, csel);
    chk({tag, "_learn"}, learn_pulse, 1);
    chk_outs(tag);
    cyc = lat;
    repeat (dd) begin tick; cyc++; end
    draw_done = 1'b1; tick; cyc++; draw_done = 1'b0;
    while (cyc < hold) begin tick; cyc++; end
    if (glitch) begin
      play_n = 1'b1; tick; tick;
      play_n = 1'b0; repeat (3) tick;
      chk({tag, "_glitch_busy"}, busy, 1);
    end
    play_n = 1'b1;
    wait_idle(tag);
    chk({tag, "_lp_count"}, lp_cnt - lp0, 1);
    chk({tag, "_ds_count"}, ds_cnt - ds0, 1);
    chk_outs({tag, "_hold"});
  endtask

  task automatic do_reset;
    reset = 1'b1; play_n = 1'b1; draw_done = 1'b0; tick; tick;
    reset = 1'b0; model_reset;
    chk_outs("reset");
    chk("reset_ctl", {busy, learn_pulse, draw_start}, 0);
  endtask

  task automatic bounce(input string tag);
    int lp0 = lp_cnt, ds0 = ds_cnt;
    play_n = 1'b0; repeat (3) tick;
    play_n = 1'b1; repeat (8) tick;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_strobes"}, (lp_cnt - lp0) + (ds_cnt - ds0), 0);
    chk_outs(tag);
  endtask

  initial begin
    int lat, lp0, ds0;
    logic [1:0] cc, rm;
    reset = 1'b1; play_n = 1'b1; re_ready = 1'b0; draw_done = 1'b0;
    mode = 2'd0; user = 2'd0; com_ra = 2'd0; com_m = 2'd0; com_re = 2'd0;
    do_reset;

    round(2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 0, 3, 20, 1'b0, "basic");
    chk("basic_uwin", uwin, 1);
    bounce("bounce1");
    bounce("bounce2");
    round(2'd1, 2'd2, 2'd0, 2'd0, 2'd2, 10, 1, 0, 1'b0, "stall");
    chk("stall_uwin", uwin, 1);

    for (int i = 0; i < 12; i++) begin
      rm = 2'($urandom);
      round(2'($urandom_range(2, 0)), rm, 2'($urandom), 2'($urandom), 2'($urandom),
            (rm == 2'd2) ? int'($urandom_range(3, 0)) : 0, int'($urandom_range(4, 0)), 0, 1'b0, "rnd");
    end

    do_reset;
    for (int i = 0; i < 15; i++) round(2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 0, 1'b0, "pre");
    chk("pre_score", user_score, 15);
    round(2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 0, 1'b0, "sat");
    chk("sat_score", user_score, 15);
    round(2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 0, 1, 0, 1'b0, "draw");
    chk("draw_equ", equ, 1);

    lp0 = lp_cnt; ds0 = ds_cnt;
    user = 2'd3; mode = 2'd0; com_ra = 2'd0; play_n = 1'b0;
    repeat (15) tick;
    chk("inv_busy", busy, 1);
    play_n = 1'b1;
    wait_idle("inv");
    chk("inv_strobes", (lp_cnt - lp0) + (ds_cnt - ds0), 0);
    chk_outs("inv");

    round(2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 0, 0, 200, 1'b1, "held");
    round(2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 0, 0, 0, 1'b0, "after_held");

    play_n = 1'b0; repeat (4) tick;
    chk("rp_busy", busy, 1);
    reset = 1'b1; play_n = 1'b1; tick; reset = 1'b0;
    model_reset;
    chk_outs("rst_press");
    chk("rst_press_ctl", {busy, learn_pulse, draw_start}, 0);
    ds0 = ds_cnt;
    draw_done = 1'b1; tick; draw_done = 1'b0; repeat (3) tick;
    chk("rst_press_dd", {busy, 1'(ds_cnt != ds0)}, 0);

    user = 2'd0; mode = 2'd0; com_ra = 2'd1;
    press_to_draw(0, lat, cc);
    chk("rd_lat", lat, 9);
    reset = 1'b1; play_n = 1'b1; tick; reset = 1'b0;
    model_reset;
    chk_outs("rst_draw");
    chk("rst_draw_ctl", {busy, learn_pulse, draw_start}, 0);
    ds0 = ds_cnt;
    draw_done = 1'b1; tick; draw_done = 1'b0; repeat (3) tick;
    chk("rst_draw_dd", {busy, 1'(ds_cnt != ds0)}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
